// File: rtl/seq_divider_pkg.sv
// Shared definitions for the Sextium III datapath.
//   DATA_WIDTH : default operand/result width of the datapath
//   alu_op_e   : ALU opcode encodings; the control unit keys its divide
//                stall on ALU_DIV
package seq_divider_pkg;

  localparam int unsigned DATA_WIDTH = 16;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_MUL   = 3'b010,
    ALU_DIV   = 3'b011,
    ALU_SHIFT = 3'b100,
    ALU_NAND  = 3'b101
  } alu_op_e;

  // True for the opcode that must hold the instruction until the divider
  // reports done.
  function automatic logic is_div_op(input alu_op_e op);
    return op == ALU_DIV;
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration (purely combinational).
//   rem_in   : current partial remainder (always < divisor)
//   dbit     : next dividend bit, shifted in at the bottom
//   divisor  : divisor magnitude
//   rem_out  : new partial remainder
//   qbit     : resulting quotient bit
module div_step
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dbit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             qbit
);

  // {rem_in, dbit} is WIDTH+1 bits; one more bit catches the borrow.
  logic [WIDTH+1:0] trial;
  logic             unused_trial_bit;

  always_comb begin
    trial   = {1'b0, rem_in, dbit} - {2'b00, divisor};
    qbit    = ~trial[WIDTH+1];
    // When the subtraction fails, {rem_in, dbit} < divisor so it fits in
    // WIDTH bits and the dropped MSB is zero.
    rem_out = qbit ? trial[WIDTH-1:0] : {rem_in[WIDTH-2:0], dbit};
  end

  // A successful difference is < divisor, so bit WIDTH is always zero.
  assign unused_trial_bit = trial[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Iterative signed restoring divider with a start/done handshake.
// One quotient bit per cycle, a single subtractor (div_step).
//   clock    : rising-edge clock
//   reset_n  : asynchronous active-low reset; aborts any operation
//   start    : request, sampled only while idle
//   numer    : signed dividend, captured on the accepting edge
//   denom    : signed divisor, captured on the accepting edge
//   busy     : high from the edge after acceptance until done rises
//   done     : one-cycle pulse, results valid from this cycle on
//   quotient : signed quotient, truncated toward zero
//   remain   : signed remainder, sign follows numer
//   divzero  : last operation had denom == 0 (held with the results)
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] numer,
  input  logic [WIDTH-1:0] denom,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remain,
  output logic             divzero
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  // S_ZERO is the single-cycle divide-by-zero completion path.
  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_ZERO
  } state_e;

  state_e           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] qd;      // dividend bits shift out the top, quotient bits in the bottom
  logic [WIDTH-1:0] dvs;
  logic             sign_q;
  logic             sign_r;

  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    // The most negative value maps to 2^(WIDTH-1), which fits unsigned.
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_in (rem),
    .dbit   (qd[WIDTH-1]),
    .divisor(dvs),
    .rem_out(step_rem),
    .qbit   (step_q)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      rem      <= '0;
      qd       <= '0;
      dvs      <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      quotient <= '0;
      remain   <= '0;
      divzero  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            sign_q <= numer[WIDTH-1] ^ denom[WIDTH-1];
            sign_r <= numer[WIDTH-1];
            rem    <= '0;
            dvs    <= mag(denom);
            cnt    <= CW'(WIDTH - 1);
            if (denom == '0) begin
              // qd carries the raw dividend to the remainder output.
              qd    <= numer;
              state <= S_ZERO;
            end else begin
              qd    <= mag(numer);
              busy  <= 1'b1;
              state <= S_RUN;
            end
          end
        end

        S_RUN: begin
          rem <= step_rem;
          qd  <= {qd[WIDTH-2:0], step_q};
          if (cnt == '0) begin
            state <= S_FIX;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_FIX: begin
          // -2^(WIDTH-1) / -1 wraps naturally: magnitude 2^(WIDTH-1), no negate.
          quotient <= sign_q ? (~qd + 1'b1) : qd;
          remain   <= sign_r ? (~rem + 1'b1) : rem;
          divzero  <= 1'b0;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end

        S_ZERO: begin
          quotient <= '0;
          remain   <= qd;
          divzero  <= 1'b1;
          done     <= 1'b1;
          state    <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
